// File: rtl/rst_seq_gen.sv
// Reset sequencer: synchronises rst_n, holds, releases NCH resets staggered, then runs a clock-enable divider.
// Optional `RST_SEQ_STATUS_EN adds an 8-bit saturating count of completed software resets (sw_rst_cnt).
module rst_seq_gen #(
  parameter int NCH         = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGGER     = 2,
  parameter int DIV_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_rst_req,
  input  logic [DIV_W-1:0] div_val,
  output logic [NCH-1:0]   rst_n_out,
  output logic             ready,
  output logic             sw_rst_ack,
  output logic             ce,
`ifdef RST_SEQ_STATUS_EN
  output logic [7:0]       sw_rst_cnt,
`endif
  output logic [1:0]       o_dbg_state
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NCH - 1);
  localparam logic [NCH-1:0]   CH_ONE    = NCH'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  state_t            r_state;
  logic [1:0]        r_sync;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [NCH-1:0]    r_rst_n_out;
  logic              r_ready;
  logic              r_ack;
  logic              r_ce;
  logic              r_sw_seq;
  logic [DIV_W-1:0]  r_div_lat;
  logic [DIV_W-1:0]  r_div_cnt;
  logic              w_run_entry;

  assign w_run_entry = (r_state == S_RELEASE) && (r_idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  // Handshake: sw_rst_req is a level sampled only while in RUN; sw_rst_ack is a
  // one-cycle pulse on the RUN-entry edge of a software-initiated sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rst_n_out <= '0;
      r_ready     <= 1'b0;
      r_ack       <= 1'b0;
      r_ce        <= 1'b0;
      r_sw_seq    <= 1'b0;
      r_div_lat   <= '0;
      r_div_cnt   <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The edge leaving IDLE already counts as the first hold cycle.
          if (r_sync[1]) begin
            if (HOLD_CYCLES == 1) begin
              r_state     <= S_RELEASE;
              r_rst_n_out <= CH_ONE;
              r_cnt       <= '0;
              r_idx       <= '0;
            end else begin
              r_state <= S_HOLD;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_state     <= S_RELEASE;
            r_rst_n_out <= CH_ONE;
            r_cnt       <= '0;
            r_idx       <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (w_run_entry) begin
            r_state   <= S_RUN;
            r_ready   <= 1'b1;
            r_ack     <= r_sw_seq;
            r_sw_seq  <= 1'b0;
            r_div_lat <= div_val;
            r_div_cnt <= '0;
            r_ce      <= 1'b0;
            r_cnt     <= '0;
          end else if (r_cnt == STAG_LAST) begin
            r_cnt       <= '0;
            r_idx       <= r_idx + 1'b1;
            r_rst_n_out <= (r_rst_n_out << 1) | CH_ONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (sw_rst_req) begin
            r_state     <= S_HOLD;
            r_rst_n_out <= '0;
            r_ready     <= 1'b0;
            r_ce        <= 1'b0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_div_lat   <= '0;
            r_div_cnt   <= '0;
            r_sw_seq    <= 1'b1;
          end else if (r_div_cnt == r_div_lat) begin
            // Period boundary: new divider value only takes effect here.
            r_ce      <= 1'b1;
            r_div_cnt <= '0;
            r_div_lat <= div_val;
          end else begin
            r_ce      <= 1'b0;
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RST_SEQ_STATUS_EN
  logic [7:0] r_sw_rst_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_rst_cnt <= 8'd0;
    end else if (w_run_entry && r_sw_seq && (r_sw_rst_cnt != 8'hFF)) begin
      r_sw_rst_cnt <= r_sw_rst_cnt + 8'd1;
    end
  end

  assign sw_rst_cnt = r_sw_rst_cnt;
`endif

  assign rst_n_out   = r_rst_n_out;
  assign ready       = r_ready;
  assign sw_rst_ack  = r_ack;
  assign ce          = r_ce;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Randomised bench for rst_seq_gen: an edge-time reference model feeds an expected queue,
// a negedge monitor pops and compares every cycle.
module tb_rst_seq_gen;
  localparam int NCH   = 3;
  localparam int HOLD  = 4;
  localparam int STAG  = 2;
  localparam int DIV_W = 8;
  localparam int W     = NCH + 3 + 8;
`ifdef RST_SEQ_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sw_rst_req = 1'b0;
  logic [DIV_W-1:0] div_val = '0;
  logic [NCH-1:0]   rst_n_out;
  logic             ready;
  logic             sw_rst_ack;
  logic             ce;
  logic [1:0]       dbg_state;
  logic [7:0]       dut_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  rst_seq_gen #(
    .NCH(NCH), .HOLD_CYCLES(HOLD), .STAGGER(STAG), .DIV_W(DIV_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_rst_req(sw_rst_req),
    .div_val(div_val),
    .rst_n_out(rst_n_out),
    .ready(ready),
    .sw_rst_ack(sw_rst_ack),
    .ce(ce),
`ifdef RST_SEQ_STATUS_EN
    .sw_rst_cnt(dut_cnt),
`endif
    .o_dbg_state(dbg_state)
  );

`ifndef RST_SEQ_STATUS_EN
  assign dut_cnt = 8'd0;
`endif

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: sequence timing expressed as edge numbers.
  // e = edges since rst_n went high, t0 = edge the current sequence is measured from.
  int e = 0;
  int t0 = 2;
  int re = 0;
  int next_tick = 0;
  int m_cnt = 0;
  bit sw_seq = 1'b0;

  always @(posedge clk) begin
    logic [NCH-1:0] x_rn;
    logic           x_rdy, x_ack, x_ce;
    logic [7:0]     x_cnt;
    x_rn = '0; x_rdy = 1'b0; x_ack = 1'b0; x_ce = 1'b0;
    if (!rst_n) begin
      e = 0; t0 = 2; sw_seq = 1'b0; m_cnt = 0;
    end else begin
      e++;
      re = t0 + HOLD + (NCH - 1) * STAG + 1;
      if (e > re && sw_rst_req) begin
        t0 = e;
        sw_seq = 1'b1;
      end else begin
        for (int i = 0; i < NCH; i++) x_rn[i] = (e >= t0 + HOLD + i * STAG);
        x_rdy = (e >= re);
        if (e == re) begin
          x_ack = sw_seq;
          next_tick = re + int'(div_val) + 1;
          if (sw_seq && m_cnt < 255) m_cnt++;
        end else if (e > re && e == next_tick) begin
          x_ce = 1'b1;
          next_tick = e + int'(div_val) + 1;
        end
      end
    end
    x_cnt = STATUS_EN ? 8'(m_cnt) : 8'd0;
    exp_q.push_back({x_rn, x_rdy, x_ack, x_ce, x_cnt});
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] got, exp_v;
    got = {rst_n_out, ready, sw_rst_ack, ce, dut_cnt};
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_empty t=%0t got=%h", $time, got);
    end else begin
      exp_v = exp_q.pop_front();
      if (got === exp_v) n_pass++;
      else $display("FAIL cycle t=%0t got rn=%b rdy=%b ack=%b ce=%b cnt=%0d exp rn=%b rdy=%b ack=%b ce=%b cnt=%0d",
                    $time, got[W-1 -: NCH], got[10], got[9], got[8], got[7:0],
                    exp_v[W-1 -: NCH], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic async_reset_now(input int low_cycles);
    logic [W-1:0] got;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    got = {rst_n_out, ready, sw_rst_ack, ce, dut_cnt};
    n_checks++;
    if (got === '0) n_pass++;
    else $display("FAIL async_reset t=%0t got=%h exp=0", $time, got);
    repeat (low_cycles) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_cnt(input string name, input logic [7:0] exp_c);
    n_checks++;
    if (dut_cnt === exp_c) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", name, dut_cnt, exp_c);
  endtask

  initial begin
    // power-on
    rst_n = 1'b0; div_val = 8'd3;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (22) step();
    // divider change mid-period
    repeat (2) step();
    div_val = 8'd0;
    repeat (10) step();
    // software reset pulse
    div_val = 8'd2;
    sw_rst_req = 1'b1; step(); sw_rst_req = 1'b0;
    repeat (15) step();
    // request during HOLD/RELEASE is ignored
    sw_rst_req = 1'b1; step(); sw_rst_req = 1'b0;
    repeat (2) step();
    sw_rst_req = 1'b1; repeat (5) step(); sw_rst_req = 1'b0;
    repeat (12) step();
    // async reset between E7 and E8
    async_reset_now(2);
    repeat (7) @(posedge clk);
    async_reset_now(2);
    repeat (20) step();
    // randomised phase
    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(0, 99) < 8) div_val = DIV_W'($urandom_range(0, 6));
      sw_rst_req = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 249) == 0) async_reset_now($urandom_range(1, 3));
      step();
    end
    sw_rst_req = 1'b0;
    // status counter: three software resets from a clean power-on
    async_reset_now(2);
    repeat (15) step();
    for (int k = 0; k < 3; k++) begin
      sw_rst_req = 1'b1; step(); sw_rst_req = 1'b0;
      repeat (12) step();
    end
`ifdef RST_SEQ_STATUS_EN
    check_cnt("sw_rst_cnt_three", 8'd3);
`endif
    // request held high: back-to-back sequences drive the counter to saturation
    sw_rst_req = 1'b1;
    repeat (3010) step();
    sw_rst_req = 1'b0;
    repeat (12) step();
`ifdef RST_SEQ_STATUS_EN
    check_cnt("sw_rst_cnt_sat", 8'd255);
`endif
    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rst_seq_gen.md
# rst_seq_gen

Parametrised clock-enable and reset sequencer for lab designs and their benches. Synchronises the board reset, holds a programmable number of cycles, then releases `NCH` downstream active-low resets in staggered order. Afterwards it emits a programmable clock-enable tick and accepts software reset requests over a req/ack handshake. It sits between the clock/reset source and the design under test.

## Interface

**Parameters**
- `NCH`, 4: number of reset channels (≥1).
- `HOLD_CYCLES`, 8: cycles held in reset after synchroniser output rises (≥1).
- `STAGGER`, 2: cycles between successive channel releases (≥1).
- `DIV_W`, 8: width of the clock-enable divider value.

**Ports**
- `clk`, input, 1: single clock, all logic on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `sw_rst_req`, input, 1: software reset request, level-sampled.
- `div_val`, input, `DIV_W`: clock-enable period minus 1.
- `rst_n_out`, output, `NCH`: staggered active-low resets. Asserted asynchronously, released synchronously.
- `ready`, output, 1: sequence complete, design running.
- `sw_rst_ack`, output, 1: one-cycle pulse when a software reset sequence completes.
- `ce`, output, 1: clock-enable tick.

## Operation

- **Reset values** while `rst_n`=0 (immediate, asynchronous):
  - `rst_n_out`=0, `ready`=0, `sw_rst_ack`=0, `ce`=0.
  - Synchroniser=00, FSM=IDLE, all counters=0.
- **Synchroniser:** 2-flop chain on `rst_n`. Its output `rs` rises on the 2nd rising edge with `rst_n`=1.
- **FSM states:** IDLE, HOLD, RELEASE, RUN.
  - IDLE → HOLD when `rs`=1.
  - HOLD counts `HOLD_CYCLES`, then enters RELEASE with `rst_n_out[0]` rising on that edge.
  - RELEASE raises `rst_n_out[i]` `STAGGER` cycles after `rst_n_out[i-1]`. After the edge raising `rst_n_out[NCH-1]`, the FSM moves to RUN on the next edge.
  - RUN sets `ready`=1.
  - RUN → HOLD when `sw_rst_req`=1 at an edge while in RUN. On that same edge all `rst_n_out`=0, `ready`=0 and counters are cleared. The sequence then repeats from HOLD.
- **Software reset handshake:**
  - `sw_rst_req` is ignored outside RUN, including the edge that enters RUN.
  - A flag records that the current sequence was software-initiated. `sw_rst_ack` pulses on the RUN-entry edge of that sequence only, never after power-on.
  - A request still high after ack starts a new sequence on the next edge.
- **Divider:**
  - Active only in RUN, cleared on leaving RUN.
  - `div_val` is latched on RUN entry and on every `ce` pulse. Mid-period changes take effect after the next tick.
  - `ce` is registered: high for one cycle every `div_val`+1 cycles.
  - `div_val`=0 → `ce` high every RUN cycle after `ready` rises.
- **Counter widths:** `$clog2` of the largest count, minimum 1 bit. The divider counter is `DIV_W` bits and wraps at the latched value, never at 2^`DIV_W`.

## Timing

- E1 is the first edge with `rst_n`=1; `rs`=1 after E2.
- Channel i releases at edge E2+`HOLD_CYCLES`+i·`STAGGER`.
- `ready` rises at E2+`HOLD_CYCLES`+(`NCH`-1)·`STAGGER`+1.
- First `ce` pulse occurs `div_val`+1 edges after `ready` rises.
- Software request sampled at edge S: all outputs drop at S. Channel i releases at S+`HOLD_CYCLES`+i·`STAGGER`. `ready` and `sw_rst_ack` rise at S+`HOLD_CYCLES`+(`NCH`-1)·`STAGGER`+1.
- `rst_n` low at any point, including mid-HOLD, mid-RELEASE or during an ack: return to reset values at once. Full power-on sequence on release, no ack.

## Configuration

- Macro `RST_SEQ_STATUS_EN`.
- **Defined:**
  - Adds output `sw_rst_cnt`, 8 bits, reset 0.
  - Increments on each `sw_rst_ack` pulse and saturates at 255.
  - Cleared only by `rst_n`.
- **Undefined:** the port and its counter are absent. All other behaviour is identical.

## Test plan

Bench parameters for all scenarios: `NCH`=3, `HOLD_CYCLES`=4, `STAGGER`=2.

- **Power-on:** `rst_n` low 3 cycles, then high at E1 → `rst_n_out` 000→001 at E6, 011 at E8, 111 at E10; `ready` at E11; `sw_rst_ack` stays 0.
- **Divider:** `div_val`=3 in RUN → `ce` high one cycle in every 4, first at `ready`+4. Change to 0 mid-period → every cycle after the next tick.
- **Software reset:** `sw_rst_req` one-cycle pulse at edge S in RUN → `rst_n_out`=000 and `ready`=0 at S; channels release at S+4/S+6/S+8; `ready` and one-cycle `sw_rst_ack` at S+9; `ce` silent until RUN.
- **Ignored request:** `sw_rst_req` high during HOLD and RELEASE, low before RUN → no restart, no ack.
- **Asynchronous reset mid-RELEASE:** `rst_n` low between E7 and E8 → outputs 0 immediately; a clean power-on sequence follows.
- **With `RST_SEQ_STATUS_EN`:** 3 software resets → `sw_rst_cnt`=3. Force 300 resets → `sw_rst_cnt`=255.
